weight_update_writer: RTL and testbench

- Fixed-point SGD update stage directly upstream of writemem.
- Accepts a stream of (address, old weight, gradient) triples and computes new weight = w − (lr·g) in Q(DWIDTH−FRAC).FRAC.
- Pairs consecutive results into one dual-port write (enable, addr1/data1, addr2/data2) that drives writemem directly.
- A flush request drains the pipeline and emits any unpaired result.

---
 rtl/wupd_pkg.sv | 20 ++
 rtl/weight_update_writer_mul.sv | 54 +++++
 rtl/weight_update_writer.sv | 229 ++++++++++++++++++++++
 tb/tb_weight_update_writer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wupd_pkg.sv
// Shared definitions for the weight update writer.
// Holds the control FSM state type and the default fixed-point constants
// (Q8.24 on a 32-bit word) used by the SGD update datapath.
package wupd_pkg;

  localparam int unsigned DWIDTH_DEF = 32;
  localparam int unsigned FRAC_DEF   = 24;
  localparam int unsigned PROD_W     = 2 * DWIDTH_DEF;

  localparam logic [DWIDTH_DEF-1:0] ONE  = DWIDTH_DEF'(1) << FRAC_DEF;
  localparam logic [DWIDTH_DEF-1:0] SMAX = {1'b0, {(DWIDTH_DEF-1){1'b1}}};
  localparam logic [DWIDTH_DEF-1:0] SMIN = {1'b1, {(DWIDTH_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } wupd_state_e;

endpackage

// File: rtl/weight_update_writer_mul.sv
// fx_mul_shift: registered signed fixed-point multiply.
// result = (a * b) >>> FRAC, computed at full 2*WIDTH precision and
// narrowed back to WIDTH bits. One cycle of latency; out_valid tracks
// in_valid.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   in_valid        operands valid this cycle
//   a, b            signed operands
//   out_valid       result valid
//   result          registered scaled product
module fx_mul_shift #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned ProdW = 2 * WIDTH;

  logic signed [ProdW-1:0] a_ext;
  logic signed [ProdW-1:0] b_ext;
  logic signed [ProdW-1:0] prod_full;
  logic signed [ProdW-1:0] prod_shift;
  logic                    unused_prod_hi;

  always_comb begin
    a_ext      = {{WIDTH{a[WIDTH-1]}}, a};
    b_ext      = {{WIDTH{b[WIDTH-1]}}, b};
    prod_full  = a_ext * b_ext;
    prod_shift = prod_full >>> FRAC;
  end

  // Bits above the narrowed result are intentionally dropped (wrap).
  assign unused_prod_hi = ^prod_shift[ProdW-1:WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= prod_shift[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/weight_update_writer.sv
// weight_update_writer: fixed-point SGD update stage feeding writemem.
// new_w = w - ((lr * g) >>> FRAC). Results are paired into one dual-port
// write strobe; flush drains the pipeline and emits an odd leftover result
// as a duplicate write to the same address.
// Build option: define WUPD_SAT_EN to saturate the subtraction and expose
// sat_flag; otherwise the result wraps and sat_flag is absent.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   lr                          signed learning rate, sampled on accept
//   in_valid/in_ready           input triple handshake
//   in_addr/in_weight/in_grad   address, old weight, gradient
//   flush/done                  drain request, completion pulse
//   enable                      one-cycle write strobe to writemem
//   addr1/data1, addr2/data2    write pair (held between strobes)
//   sat_flag                    clamp indicator (WUPD_SAT_EN only)
module weight_update_writer
  import wupd_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned FRAC   = FRAC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] lr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_addr,
  input  logic [DWIDTH-1:0] in_weight,
  input  logic [DWIDTH-1:0] in_grad,
  input  logic              flush,
  output logic              done,
  output logic              enable,
  output logic [DWIDTH-1:0] addr1,
  output logic [DWIDTH-1:0] data1,
  output logic [DWIDTH-1:0] addr2,
  output logic [DWIDTH-1:0] data2
`ifdef WUPD_SAT_EN
  ,
  output logic              sat_flag
`endif
);

  logic accept;
  assign accept = in_valid && in_ready;

  // Stage 1: scaled product, with address and weight carried alongside.
  logic              s1_valid;
  logic [DWIDTH-1:0] s1_prod;
  logic [DWIDTH-1:0] s1_addr_q;
  logic [DWIDTH-1:0] s1_weight_q;

  fx_mul_shift #(
    .WIDTH(DWIDTH),
    .FRAC (FRAC)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .a        (lr),
    .b        (in_grad),
    .out_valid(s1_valid),
    .result   (s1_prod)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_addr_q   <= '0;
      s1_weight_q <= '0;
    end else if (accept) begin
      s1_addr_q   <= in_addr;
      s1_weight_q <= in_weight;
    end
  end

  // Stage 2: subtraction one bit wider than the data so overflow is visible.
  logic [DWIDTH:0]   diff_wide;
  logic [DWIDTH-1:0] diff_narrow;

`ifdef WUPD_SAT_EN
  localparam logic [DWIDTH-1:0] SatMax = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0] SatMin = {1'b1, {(DWIDTH-1){1'b0}}};
  logic ovf;
  always_comb begin
    diff_wide   = {s1_weight_q[DWIDTH-1], s1_weight_q} - {s1_prod[DWIDTH-1], s1_prod};
    ovf         = diff_wide[DWIDTH] ^ diff_wide[DWIDTH-1];
    diff_narrow = ovf ? (diff_wide[DWIDTH] ? SatMin : SatMax) : diff_wide[DWIDTH-1:0];
  end
`else
  logic unused_diff_msb;
  always_comb begin
    diff_wide   = {s1_weight_q[DWIDTH-1], s1_weight_q} - {s1_prod[DWIDTH-1], s1_prod};
    diff_narrow = diff_wide[DWIDTH-1:0];
  end
  assign unused_diff_msb = diff_wide[DWIDTH];
`endif

  logic              s2_valid_q;
  logic [DWIDTH-1:0] s2_addr_q;
  logic [DWIDTH-1:0] s2_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid;
      if (s1_valid) begin
        s2_addr_q <= s1_addr_q;
        s2_data_q <= diff_narrow;
      end
    end
  end

`ifdef WUPD_SAT_EN
  logic sat_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= s1_valid && ovf;
    end
  end
  assign sat_flag = sat_q;
`endif

  // Pair slot, write outputs and control FSM.
  wupd_state_e       state_q, state_d;
  logic              slot_full_q, slot_full_d;
  logic [DWIDTH-1:0] slot_addr_q, slot_addr_d;
  logic [DWIDTH-1:0] slot_data_q, slot_data_d;
  logic              enable_q, enable_d;
  logic [DWIDTH-1:0] addr1_q, addr1_d, data1_q, data1_d;
  logic [DWIDTH-1:0] addr2_q, addr2_d, data2_q, data2_d;
  logic              in_ready_q, done_q;

  always_comb begin
    state_d     = state_q;
    slot_full_d = slot_full_q;
    slot_addr_d = slot_addr_q;
    slot_data_d = slot_data_q;
    enable_d    = 1'b0;
    addr1_d     = addr1_q;
    data1_d     = data1_q;
    addr2_d     = addr2_q;
    data2_d     = data2_q;

    if (s2_valid_q) begin
      if (!slot_full_q) begin
        slot_full_d = 1'b1;
        slot_addr_d = s2_addr_q;
        slot_data_d = s2_data_q;
      end else begin
        enable_d    = 1'b1;
        addr1_d     = slot_addr_q;
        data1_d     = slot_data_q;
        addr2_d     = s2_addr_q;
        data2_d     = s2_data_q;
        slot_full_d = 1'b0;
      end
    end

    unique case (state_q)
      RUN: begin
        if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // With both stages empty no pairing can happen, so the slot is free
        // to be emitted as a duplicate write to the same address.
        if (!s1_valid && !s2_valid_q) begin
          if (slot_full_q) begin
            enable_d    = 1'b1;
            addr1_d     = slot_addr_q;
            data1_d     = slot_data_q;
            addr2_d     = slot_addr_q;
            data2_d     = slot_data_q;
            slot_full_d = 1'b0;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      slot_full_q <= 1'b0;
      slot_addr_q <= '0;
      slot_data_q <= '0;
      enable_q    <= 1'b0;
      addr1_q     <= '0;
      data1_q     <= '0;
      addr2_q     <= '0;
      data2_q     <= '0;
      in_ready_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_full_q <= slot_full_d;
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
      enable_q    <= enable_d;
      addr1_q     <= addr1_d;
      data1_q     <= data1_d;
      addr2_q     <= addr2_d;
      data2_q     <= data2_d;
      in_ready_q  <= (state_d == RUN);
      done_q      <= (state_d == DONE);
    end
  end

  assign in_ready = in_ready_q;
  assign done     = done_q;
  assign enable   = enable_q;
  assign addr1    = addr1_q;
  assign data1    = data1_q;
  assign addr2    = addr2_q;
  assign data2    = data2_q;

endmodule

// File: tb/tb_weight_update_writer.sv
// Directed bench for weight_update_writer (default DWIDTH=32, FRAC=24).
module tb_weight_update_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_weight;
  logic [31:0] in_grad;
  logic        flush;
  logic        done;
  logic        enable;
  logic [31:0] addr1, data1, addr2, data2;
`ifdef WUPD_SAT_EN
  logic        sat_flag;
  int          sat_cnt = 0;
`endif

  weight_update_writer #(
    .DWIDTH(32),
    .FRAC  (24)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .lr       (lr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_weight(in_weight),
    .in_grad  (in_grad),
    .flush    (flush),
    .done     (done),
    .enable   (enable),
    .addr1    (addr1),
    .data1    (data1),
    .addr2    (addr2),
    .data2    (data2)
`ifdef WUPD_SAT_EN
    ,
    .sat_flag (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [31:0] a2;
    logic [31:0] d2;
  } ev_t;

  ev_t evq[$];
  int  doneq[$];

  always @(negedge clk) begin
    if (enable) evq.push_back('{cyc, addr1, data1, addr2, data2});
    if (done) doneq.push_back(cyc);
`ifdef WUPD_SAT_EN
    if (sat_flag) sat_cnt <= sat_cnt + 1;
`endif
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Present one triple for a cycle; edge is the clock edge that accepts it.
  task automatic send(input logic [31:0] a, input logic [31:0] w, input logic [31:0] g,
                      output int edge_n);
    in_valid  = 1'b1;
    in_addr   = a;
    in_weight = w;
    in_grad   = g;
    edge_n    = cyc + 1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".enable"}, 64'(enable), 64'(0));
    check({tag, ".done"}, 64'(done), 64'(0));
    check({tag, ".in_ready"}, 64'(in_ready), 64'(0));
    check({tag, ".addr1"}, 64'(addr1), 64'(0));
    check({tag, ".data1"}, 64'(data1), 64'(0));
    check({tag, ".addr2"}, 64'(addr2), 64'(0));
    check({tag, ".data2"}, 64'(data2), 64'(0));
  endtask

  int          e1, e2, ef, ee;
  int          rdy[0:15];
  int          d_ofs;
  logic        bad;
  logic [31:0] sat_exp;

  initial begin
    rst       = 1'b0;
    lr        = '0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_weight = '0;
    in_grad   = '0;
    flush     = 1'b0;

    // Reset state
    tick();
    tick();
    check_outputs_zero("reset");
    rst = 1'b1;
    check("ready_before_edge", 64'(in_ready), 64'(0));
    tick();
    check("ready_after_release", 64'(in_ready), 64'(1));

    // Basic pair: 0.5 * 0.5 = 0.25 -> 1.0-0.25; 0.5 * 1.0 -> 0-0.5
    evq.delete(); doneq.delete();
    lr = 32'h0080_0000;
    send(32'd3, 32'h0100_0000, 32'h0080_0000, e1);
    send(32'd4, 32'h0000_0000, 32'h0100_0000, e2);
    repeat (6) tick();
    check("pair.count", 64'(evq.size()), 64'(1));
    if (evq.size() == 1) begin
      check("pair.cycle", 64'(evq[0].cyc), 64'(e2 + 2));
      check("pair.addr1", 64'(evq[0].a1), 64'(3));
      check("pair.data1", 64'(evq[0].d1), 64'h00C0_0000);
      check("pair.addr2", 64'(evq[0].a2), 64'(4));
      check("pair.data2", 64'(evq[0].d2), 64'hFF80_0000);
    end
    check("pair.hold_enable", 64'(enable), 64'(0));
    check("pair.hold_data2", 64'(data2), 64'hFF80_0000);
    check("pair.no_done", 64'(doneq.size()), 64'(0));

    // Odd count plus flush (flush with the third triple), lr = 1.0
    evq.delete(); doneq.delete();
    lr = 32'h0100_0000;
    send(32'd10, 32'h0200_0000, 32'h0040_0000, e1);  // 2.0-0.25
    send(32'd11, 32'h0000_0000, 32'hFFC0_0000, e1);  // 0+0.25
    flush = 1'b1;
    send(32'd12, 32'h0050_0000, 32'h0020_0000, ef);  // 0x50_0000-0x20_0000
    flush = 1'b0;
    rdy[0] = int'(in_ready);
    for (int k = 1; k < 16; k++) begin
      tick();
      rdy[k] = int'(in_ready);
    end
    check("odd.count", 64'(evq.size()), 64'(2));
    check("odd.done_count", 64'(doneq.size()), 64'(1));
    if (evq.size() == 2) begin
      check("odd.p_addr1", 64'(evq[0].a1), 64'(10));
      check("odd.p_data1", 64'(evq[0].d1), 64'h01C0_0000);
      check("odd.p_addr2", 64'(evq[0].a2), 64'(11));
      check("odd.p_data2", 64'(evq[0].d2), 64'h0040_0000);
      check("odd.dup_addr1", 64'(evq[1].a1), 64'(12));
      check("odd.dup_addr2", 64'(evq[1].a2), 64'(12));
      check("odd.dup_data1", 64'(evq[1].d1), 64'h0030_0000);
      check("odd.dup_data2", 64'(evq[1].d2), 64'h0030_0000);
      if (doneq.size() == 1) begin
        check("odd.done_not_before_dup", 64'(doneq[0] >= evq[1].cyc), 64'(1));
      end
    end
    if (doneq.size() == 1) begin
      d_ofs = doneq[0] - ef;
      check("odd.done_in_window", 64'(d_ofs >= 0 && d_ofs < 15), 64'(1));
      if (d_ofs >= 0 && d_ofs < 15) begin
        bad = 1'b0;
        for (int k = 0; k <= d_ofs; k++) if (rdy[k] != 0) bad = 1'b1;
        check("odd.ready_low_during_drain", 64'(bad), 64'(0));
        check("odd.ready_after_done", 64'(rdy[d_ofs + 1]), 64'(1));
      end
    end

    // Saturation corner: 0x7FFF_FFFF - (-1.0)
`ifdef WUPD_SAT_EN
    sat_exp = 32'h7FFF_FFFF;
    sat_cnt = 0;
`else
    sat_exp = 32'h80FF_FFFF;
`endif
    evq.delete(); doneq.delete();
    lr = 32'h0100_0000;
    flush = 1'b1;
    send(32'd20, 32'h7FFF_FFFF, 32'hFF00_0000, e1);
    flush = 1'b0;
    repeat (10) tick();
    check("sat.count", 64'(evq.size()), 64'(1));
    if (evq.size() == 1) begin
      check("sat.addr1", 64'(evq[0].a1), 64'(20));
      check("sat.addr2", 64'(evq[0].a2), 64'(20));
      check("sat.data1", 64'(evq[0].d1), 64'(sat_exp));
      check("sat.data2", 64'(evq[0].d2), 64'(sat_exp));
    end
    check("sat.done_count", 64'(doneq.size()), 64'(1));
`ifdef WUPD_SAT_EN
    check("sat.flag_pulses", 64'(sat_cnt), 64'(1));
`endif

    // Back-to-back stream: w=i, g=i, lr=0.5 -> data = i/2 = i<<23
    evq.delete(); doneq.delete();
    lr = 32'h0080_0000;
    in_valid = 1'b1;
    e1 = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      in_addr   = 32'h40 + 32'(i);
      in_weight = 32'(i) << 24;
      in_grad   = 32'(i) << 24;
      tick();
    end
    in_valid = 1'b0;
    repeat (8) tick();
    check("b2b.count", 64'(evq.size()), 64'(4));
    if (evq.size() == 4) begin
      check("b2b.first_cycle", 64'(evq[0].cyc), 64'(e1 + 3));
      for (int k = 0; k < 4; k++) begin
        check($sformatf("b2b.addr1[%0d]", k), 64'(evq[k].a1), 64'(32'h40 + 32'(2 * k)));
        check($sformatf("b2b.data1[%0d]", k), 64'(evq[k].d1), 64'(32'(2 * k) << 23));
        check($sformatf("b2b.addr2[%0d]", k), 64'(evq[k].a2), 64'(32'h41 + 32'(2 * k)));
        check($sformatf("b2b.data2[%0d]", k), 64'(evq[k].d2), 64'(32'(2 * k + 1) << 23));
        if (k > 0) begin
          check($sformatf("b2b.spacing[%0d]", k), 64'(evq[k].cyc - evq[k-1].cyc), 64'(2));
        end
      end
    end
    check("b2b.no_done", 64'(doneq.size()), 64'(0));

    // Flush with empty pipeline: done two cycles after flush, no strobe
    evq.delete(); doneq.delete();
    flush = 1'b1;
    ee = cyc + 1;
    tick();
    flush = 1'b0;
    repeat (6) tick();
    check("idle_flush.done_count", 64'(doneq.size()), 64'(1));
    if (doneq.size() == 1) begin
      check("idle_flush.done_cycle", 64'(doneq[0]), 64'(ee + 1));
    end
    check("idle_flush.no_enable", 64'(evq.size()), 64'(0));

    // Reset mid-stream: accepted triple must never be written
    evq.delete(); doneq.delete();
    lr = 32'h0100_0000;
    send(32'h55, 32'h0100_0000, 32'h0010_0000, e1);
    rst = 1'b0;
    tick();
    tick();
    check_outputs_zero("midreset");
    rst = 1'b1;
    repeat (8) tick();
    check("midreset.no_enable", 64'(evq.size()), 64'(0));
    check("midreset.addr1", 64'(addr1), 64'(0));
    check("midreset.data2", 64'(data2), 64'(0));
    check("midreset.ready_back", 64'(in_ready), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
